// File: rtl/mul_acc_stage.sv
// Multiply-accumulate stage: bursts of operand pairs are multiplied and summed.
// Optional saturating accumulation is enabled with `define MUL_ACC_SATURATE_EN.
module mul_acc_stage #(
    parameter int unsigned n     = 8,
    parameter int unsigned acc_w = 2 * n + 8,
    parameter int unsigned cnt_w = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [cnt_w-1:0] len,
    input  logic             signed_mul,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [acc_w-1:0] res,
    output logic             busy,
    output logic             ovf
);
    localparam int unsigned PW = 2 * n;
    localparam logic [cnt_w-1:0] CntOne = cnt_w'(1);

    typedef enum logic [1:0] {StIdle, StAcc, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [cnt_w-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             signed_q, signed_d;
    logic [PW-1:0]    prod_q, prod_d, op_a, op_b;
    logic             prod_vld_q, prod_vld_d;
    logic [acc_w-1:0] acc_q, acc_d, acc_nxt, res_q, res_d;
    logic             ovf_q, ovf_d, clamp;

    // Low PW bits of the product of extended operands equal the signed/unsigned product.
    assign op_a = {{n{a[n-1] & signed_q}}, a};
    assign op_b = {{n{b[n-1] & signed_q}}, b};

`ifdef MUL_ACC_SATURATE_EN
    localparam int unsigned EW = acc_w + 1;
    logic [EW-1:0] sum;

    always_comb begin
        sum = {acc_q[acc_w-1] & signed_q, acc_q}
            + {{(EW-PW){prod_q[PW-1] & signed_q}}, prod_q};
        acc_nxt = sum[acc_w-1:0];
        clamp   = 1'b0;
        if (ovf_q) begin
            acc_nxt = acc_q;
        end else if (signed_q) begin
            if (sum[acc_w] != sum[acc_w-1]) begin
                clamp   = 1'b1;
                acc_nxt = sum[acc_w] ? {1'b1, {(acc_w-1){1'b0}}} : {1'b0, {(acc_w-1){1'b1}}};
            end
        end else if (sum[acc_w]) begin
            clamp   = 1'b1;
            acc_nxt = '1;
        end
    end
`else
    logic [acc_w-1:0] prod_ext;

    always_comb begin
        if (signed_q) begin
            prod_ext = acc_w'($signed(prod_q));
        end else begin
            prod_ext = acc_w'(prod_q);
        end
        acc_nxt = acc_q + prod_ext;
        clamp   = 1'b0;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        signed_d   = signed_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        res_d      = res_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state_q != StIdle);

        if (prod_vld_q) begin
            acc_d = acc_nxt;
            ovf_d = ovf_q | clamp;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d    = len;
                    signed_d = signed_mul;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                    if (len == '0) begin
                        res_d   = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    prod_d     = op_a * op_b;
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_q + CntOne;
                    if (cnt_q == len_q - CntOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Wait until the last product has landed in the accumulator.
                if (!prod_vld_q) begin
                    res_d   = acc_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            signed_q   <= 1'b0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            signed_q   <= signed_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            res_q      <= res_d;
        end
    end

    assign res = res_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Bench for mul_acc_stage: two instances (n=4, acc_w=16 and acc_w=8) share stimulus.
// Honours MUL_ACC_SATURATE_EN for the expected values of the narrow instance.
module tb_mul_acc_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, signed_mul, in_valid, out_ready;
    logic [7:0] len;
    logic [3:0] a, b;

    logic        in_ready_w, out_valid_w, busy_w, ovf_w;
    logic [15:0] res_w;
    logic        in_ready_n, out_valid_n, busy_n, ovf_n;
    logic [7:0]  res_n;

    int total = 0;
    int bad   = 0;

`ifdef MUL_ACC_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    mul_acc_stage #(.n(4), .acc_w(16), .cnt_w(8)) dut_w (
        .clk(clk), .rst(rst), .start(start), .len(len), .signed_mul(signed_mul),
        .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
        .out_valid(out_valid_w), .out_ready(out_ready), .res(res_w),
        .busy(busy_w), .ovf(ovf_w)
    );

    mul_acc_stage #(.n(4), .acc_w(8), .cnt_w(8)) dut_n (
        .clk(clk), .rst(rst), .start(start), .len(len), .signed_mul(signed_mul),
        .in_valid(in_valid), .in_ready(in_ready_n), .a(a), .b(b),
        .out_valid(out_valid_n), .out_ready(out_ready), .res(res_n),
        .busy(busy_n), .ovf(ovf_n)
    );

    typedef struct packed {
        logic        sgn;
        logic [7:0]  ln;
        logic [31:0] av;   // nibble i = operand a of pair i
        logic [31:0] bv;
        logic [3:0]  gap;
        logic [3:0]  hold;
        logic [15:0] exp_w;
        logic [7:0]  exp_nw;  // narrow instance, wrapping
        logic [7:0]  exp_ns;  // narrow instance, saturating
        logic        ovf_ns;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer sum of products, clamped per add when saturating.
    function automatic logic [15:0] model(input bit sgn, input int ln, input logic [31:0] av,
                                          input logic [31:0] bv, input int w, output bit ov);
        longint s, p;
        int     x, y;
`ifdef MUL_ACC_SATURATE_EN
        longint lo, hi;
        bit     cl;
        cl = 1'b0;
        if (sgn) begin
            lo = -(longint'(1) <<< (w - 1));
            hi = (longint'(1) <<< (w - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) <<< w) - 1;
        end
`endif
        s  = 0;
        ov = 1'b0;
        for (int i = 0; i < ln; i++) begin
            x = int'(av[4*i +: 4]);
            y = int'(bv[4*i +: 4]);
            if (sgn) begin
                if (x > 7) x -= 16;
                if (y > 7) y -= 16;
            end
            p = longint'(x * y);
`ifdef MUL_ACC_SATURATE_EN
            if (!cl) begin
                s += p;
                if (s > hi) begin
                    s = hi; cl = 1'b1; ov = 1'b1;
                end else if (s < lo) begin
                    s = lo; cl = 1'b1; ov = 1'b1;
                end
            end
`else
            s += p;
`endif
        end
        return 16'(s & ((longint'(1) <<< w) - 1));
    endfunction

    // Called and returns on a negedge; inputs change only on negedges.
    task automatic run_burst(input bit sgn, input int ln, input logic [31:0] av,
                             input logic [31:0] bv, input int gap, input int hold,
                             input bit pulse_start, input logic [15:0] exp_w,
                             input logic [7:0] exp_n, input bit exp_ovf_n);
        check("idle_in_ready", {in_ready_w, in_ready_n}, 0);
        start = 1'b1; len = 8'(ln); signed_mul = sgn;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < ln; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1; a = av[4*i +: 4]; b = bv[4*i +: 4];
            check("acc_in_ready", {in_ready_w, in_ready_n}, 2'b11);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (ln != 0) begin
            check("lat_e0_valid", {out_valid_w, out_valid_n, in_ready_w, in_ready_n}, 0);
            @(negedge clk);
            check("lat_e1_valid", {out_valid_w, out_valid_n, in_ready_w, in_ready_n}, 0);
            @(negedge clk);
        end
        check("done_valid", {out_valid_w, out_valid_n, in_ready_w, in_ready_n}, 4'b1100);
        check("res_wide", res_w, exp_w);
        check("res_narrow", res_n, exp_n);
        check("ovf", {ovf_w, ovf_n}, {1'b0, exp_ovf_n});
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (pulse_start) begin
                start = 1'b1; len = 8'd2; signed_mul = ~sgn;
            end
            @(negedge clk);
            start = 1'b0;
            check("hold_stable", {out_valid_w, out_valid_n, res_w, res_n}, {2'b11, exp_w, exp_n});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_take", {busy_w, busy_n, out_valid_w, out_valid_n}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          sg, ovx;
        int          ln, gp, hd;
        logic [31:0] av, bv;
        logic [15:0] ew, en16;

        vecs[0] = '{1'b0, 8'd3, 32'h01FF, 32'h01FF, 4'd0, 4'd5, 16'h01C3, 8'hC3, 8'hFF, 1'b1};
        vecs[1] = '{1'b1, 8'd3, 32'h0788, 32'h0778, 4'd2, 4'd0, 16'h0039, 8'h39, 8'h39, 1'b0};
        vecs[2] = '{1'b0, 8'd2, 32'h00FF, 32'h00FF, 4'd0, 4'd0, 16'h01C2, 8'hC2, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 8'd2, 32'h0088, 32'h0088, 4'd1, 4'd0, 16'h0080, 8'h80, 8'h7F, 1'b1};
        vecs[4] = '{1'b1, 8'd1, 32'h0003, 32'h000B, 4'd0, 4'd1, 16'hFFF1, 8'hF1, 8'hF1, 1'b0};
        vecs[5] = '{1'b0, 8'd4, 32'h7531, 32'h8642, 4'd1, 4'd0, 16'h0064, 8'h64, 8'h64, 1'b0};
        vecs[6] = '{1'b1, 8'd2, 32'h0088, 32'h0077, 4'd0, 4'd2, 16'hFF90, 8'h90, 8'h90, 1'b0};
        vecs[7] = '{1'b1, 8'd3, 32'h0888, 32'h0788, 4'd0, 4'd0, 16'h0048, 8'h48, 8'h7F, 1'b1};

        rst = 1'b1; start = 1'b0; len = '0; signed_mul = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {in_ready_w, out_valid_w, busy_w, ovf_w, res_w,
                              in_ready_n, out_valid_n, busy_n, ovf_n, res_n}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_burst(vecs[v].sgn, int'(vecs[v].ln), vecs[v].av, vecs[v].bv,
                      int'(vecs[v].gap), int'(vecs[v].hold), (v == 0),
                      vecs[v].exp_w, Sat ? vecs[v].exp_ns : vecs[v].exp_nw,
                      Sat ? vecs[v].ovf_ns : 1'b0);
        end

        // Zero-length burst goes straight to DONE with a zero result.
        run_burst(1'b0, 0, 32'h0, 32'h0, 0, 2, 1'b0, 16'h0, 8'h0, 1'b0);

        // Reset in the middle of a burst discards the partial sum.
        start = 1'b1; len = 8'd4; signed_mul = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 4'hF; b = 4'hF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("mid_busy", {busy_w, busy_n}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_outs", {in_ready_w, out_valid_w, busy_w, ovf_w, res_w,
                                 in_ready_n, out_valid_n, busy_n, ovf_n, res_n}, 0);
        run_burst(1'b0, 1, 32'h3, 32'h5, 0, 0, 1'b0, 16'd15, 8'd15, 1'b0);

        for (int r = 0; r < 40; r++) begin
            sg = 1'($urandom);
            ln = int'($urandom_range(1, 8));
            av = $urandom;
            bv = $urandom;
            gp = int'($urandom_range(0, 2));
            hd = int'($urandom_range(0, 3));
            ew   = model(sg, ln, av, bv, 16, ovx);
            en16 = model(sg, ln, av, bv, 8, ovx);
            run_burst(sg, ln, av, bv, gp, hd, 1'($urandom), ew, en16[7:0], ovx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
